// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   - load_type_e / store_type_e : decoder LoadType/StoreType encodings
//   - lsu_state_e                : LSU transaction FSM states
//   - LOAD_* / STORE_*           : raw type-code constants (same bits as decoder)
//   - access_bytes()             : access size in bytes, 0 for an illegal code
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b011,
    LHU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10
  } store_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    DONE   = 2'b11
  } lsu_state_e;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;

  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

  // Size of the access in bytes (1, 2 or 4); 0 flags an undefined type code.
  function automatic logic [2:0] access_bytes(input logic       is_store,
                                              input logic [2:0] load_type,
                                              input logic [1:0] store_type);
    logic [2:0] n;
    n = 3'd0;
    if (is_store) begin
      case (store_type)
        STORE_SB: n = 3'd1;
        STORE_SH: n = 3'd2;
        STORE_SW: n = 3'd4;
        default:  n = 3'd0;
      endcase
    end else begin
      case (load_type)
        LOAD_LB, LOAD_LBU: n = 3'd1;
        LOAD_LH, LOAD_LHU: n = 3'd2;
        LOAD_LW:           n = 3'd4;
        default:           n = 3'd0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   i_we, i_load_type, i_store_type, i_addr_lo, i_wdata : the M-stage operation
//   i_ld_type_q, i_ld_addr_lo_q                         : type/offset of the
//                                                         load in flight
//   i_rdata                                             : raw memory read word
//   o_be, o_wdata       : byte enables and lane-steered store data
//   o_illegal           : undefined type code
//   o_misalign          : address not aligned to the access size
//   o_rdata_ext         : selected and sign/zero-extended load result
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_store_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_type_q,
  input  logic [1:0]  i_ld_addr_lo_q,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_illegal,
  output logic        o_misalign,
  output logic [31:0] o_rdata_ext
);

  logic [2:0]  w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Size decode, legality, alignment, byte enables and store-data replication.
  always_comb begin
    w_size     = access_bytes(i_we, i_load_type, i_store_type);
    o_illegal  = (w_size == 3'd0);
    o_misalign = 1'b0;
    o_be       = 4'b0000;
    o_wdata    = 32'h0000_0000;
    case (w_size)
      3'd1: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      3'd2: begin
        o_misalign = i_addr_lo[0];
        o_be       = 4'b0011 << i_addr_lo;
        o_wdata    = {2{i_wdata[15:0]}};
      end
      3'd4: begin
        o_misalign = (i_addr_lo != 2'b00);
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
      end
      default: begin
        o_misalign = 1'b0;
        o_be       = 4'b0000;
        o_wdata    = 32'h0000_0000;
      end
    endcase
  end

  // Pick the addressed byte/halfword of the returned word and extend it.
  always_comb begin
    case (i_ld_addr_lo_q)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_ld_addr_lo_q[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    case (i_ld_type_q)
      LOAD_LB:  o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      LOAD_LH:  o_rdata_ext = {{16{w_half[15]}}, w_half};
      LOAD_LW:  o_rdata_ext = i_rdata;
      LOAD_LBU: o_rdata_ext = {24'h00_0000, w_byte};
      LOAD_LHU: o_rdata_ext = {16'h0000, w_half};
      default:  o_rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Turns one M-stage memory operation into a req/gnt/rvalid transaction on a
// word-addressed 32-bit data port and stalls the pipeline until it completes.
// Optional build macro: LSU_TIMEOUT_EN -- aborts a transaction that spends
// TIMEOUT_CYC cycles in REQ+WAIT_R, reporting ErrM.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   MemReqM, MemWriteM        : operation valid, 1 = store
//   LoadTypeM, StoreTypeM     : decoder type codes
//   AddrM, WriteDataM         : byte address, right-aligned store data
//   StallM                    : hold F/D/E/M
//   ReadDataM, DoneM, ErrM    : extended load data, completion pulse, error
//   mem_req/we/addr/be/wdata  : data-memory request channel
//   mem_gnt                   : request accepted
//   mem_rvalid, mem_rdata     : read response
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [2:0]        LoadTypeM,
  input  logic [1:0]        StoreTypeM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [31:0]       WriteDataM,
  output logic              StallM,
  output logic [31:0]       ReadDataM,
  output logic              DoneM,
  output logic              ErrM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic [2:0]        r_ld_type;
  logic [1:0]        r_addr_lo;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_illegal;
  logic              w_misalign;
  logic [31:0]       w_rdata_ext;
  logic              w_tmo_hit;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] r_tmo_cnt;
  // Hit on the last permitted REQ/WAIT_R cycle so the abort lands exactly
  // TIMEOUT_CYC cycles after entering REQ.
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign w_tmo_hit = 1'b0;
`endif

  lsu_align u_align (
    .i_we           (MemWriteM),
    .i_load_type    (LoadTypeM),
    .i_store_type   (StoreTypeM),
    .i_addr_lo      (AddrM[1:0]),
    .i_wdata        (WriteDataM),
    .i_ld_type_q    (r_ld_type),
    .i_ld_addr_lo_q (r_addr_lo),
    .i_rdata        (mem_rdata),
    .o_be           (w_be),
    .o_wdata        (w_wdata),
    .o_illegal      (w_illegal),
    .o_misalign     (w_misalign),
    .o_rdata_ext    (w_rdata_ext)
  );

  // Transaction FSM with its request and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= {ADDR_W{1'b0}};
      r_be      <= 4'b0000;
      r_wdata   <= 32'h0000_0000;
      r_we      <= 1'b0;
      r_ld_type <= 3'b000;
      r_addr_lo <= 2'b00;
      r_err     <= 1'b0;
      r_rdata   <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt <= {CNT_W{1'b0}};
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (MemReqM) begin
            if (w_illegal || w_misalign) begin
              // Rejected without touching memory.
              r_state <= DONE;
              r_err   <= 1'b1;
              r_rdata <= 32'h0000_0000;
            end else begin
              r_state   <= REQ;
              r_err     <= 1'b0;
              r_addr    <= {AddrM[ADDR_W-1:2], 2'b00};
              r_be      <= w_be;
              r_wdata   <= w_wdata;
              r_we      <= MemWriteM;
              r_ld_type <= LoadTypeM;
              r_addr_lo <= AddrM[1:0];
`ifdef LSU_TIMEOUT_EN
              r_tmo_cnt <= {CNT_W{1'b0}};
`endif
            end
          end
        end
        REQ: begin
          // Completion takes priority over a timeout in the same cycle.
          if (mem_gnt && r_we) begin
            r_state <= DONE;
          end else if (mem_gnt && mem_rvalid) begin
            r_rdata <= w_rdata_ext;
            r_state <= DONE;
          end else if (w_tmo_hit) begin
            r_state <= DONE;
            r_err   <= 1'b1;
            r_rdata <= 32'h0000_0000;
          end else if (mem_gnt) begin
            r_state <= WAIT_R;
          end else begin
            r_state <= REQ;
          end
`ifdef LSU_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
`endif
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            r_rdata <= w_rdata_ext;
            r_state <= DONE;
          end else if (w_tmo_hit) begin
            r_state <= DONE;
            r_err   <= 1'b1;
            r_rdata <= 32'h0000_0000;
          end else begin
            r_state <= WAIT_R;
          end
`ifdef LSU_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
`endif
        end
        DONE: begin
          // The MemReqM still visible here belongs to the finishing
          // instruction, so it is never accepted again.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Stall: combinational request in IDLE (accept cycle), held while busy.
  always_comb begin
    StallM = 1'b0;
    case (r_state)
      IDLE:    StallM = MemReqM;
      REQ:     StallM = 1'b1;
      WAIT_R:  StallM = 1'b1;
      DONE:    StallM = 1'b0;
      default: StallM = 1'b0;
    endcase
  end

  // Request fields are driven only while requesting so the port idles at 0.
  assign mem_req   = (r_state == REQ);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? r_addr  : {ADDR_W{1'b0}};
  assign mem_be    = mem_req ? r_be    : 4'b0000;
  assign mem_wdata = mem_req ? r_wdata : 32'h0000_0000;

  assign DoneM     = (r_state == DONE);
  assign ErrM      = DoneM & r_err;
  assign ReadDataM = r_rdata;

endmodule
